// File: rtl/lcd_bus_reader_if.sv
// Request/response handshake between an LCD client and the lcd_bus_reader engine.
// The client drives the master side; the reader implements the slave side.
interface lcd_bus_reader_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic       req_poll;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_busy;
    logic [6:0] rsp_addr;
    logic       rsp_timeout;
    logic       rsp_err;

    modport master (
        output req_valid, req_rs, req_poll,
        input  req_ready, rsp_valid, rsp_data, rsp_busy, rsp_addr, rsp_timeout, rsp_err
    );

    modport slave (
        input  req_valid, req_rs, req_poll,
        output req_ready, rsp_valid, rsp_data, rsp_busy, rsp_addr, rsp_timeout, rsp_err
    );
endinterface

// File: rtl/lcd_bus_reader.sv
// HD44780 8-bit bus read engine: timed status/data reads with optional busy-flag polling.
// Shares the LCD bus with a writer through bus_req/bus_gnt.
module lcd_bus_reader #(
    parameter int unsigned T_AS     = 2,
    parameter int unsigned T_EH     = 25,
    parameter int unsigned T_HOLD   = 2,
    parameter int unsigned T_CYC    = 50,
    parameter logic [15:0] POLL_MAX = 16'd1000
) (
    input  logic             CLOCK_50,
    input  logic             KEY0,
    lcd_bus_reader_if.slave  rd,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic             LCD_RS,
    output logic             LCD_RW,
    output logic             LCD_EN,
    input  logic [7:0]       LCD_DATA_IN
);

    localparam int unsigned T_USED = T_AS + T_EH + T_HOLD;
    localparam int unsigned T_REC  = (T_CYC > T_USED) ? (T_CYC - T_USED) : 0;

    generate
        if (T_AS == 0 || T_EH == 0 || T_HOLD == 0 ||
            T_AS > 256 || T_EH > 256 || T_HOLD > 256 || T_REC > 256) begin : g_bad_phase
            $error("lcd_bus_reader: phase widths must be 1..256 cycles");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_RECOVER,
        S_DONE
    } state_e;

    state_e      state_q;
    logic [7:0]  phase_q;
    logic [15:0] poll_cnt_q;
    logic        rs_q;
    logic        poll_q;
    logic        bus_req_q;
    logic        lcd_rs_q;
    logic        lcd_rw_q;
    logic        lcd_en_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_data_q;
    logic        rsp_busy_q;
    logic [6:0]  rsp_addr_q;
    logic        rsp_timeout_q;
    logic        rsp_err_q;
    logic        more_poll_d;
    logic        on_bus;

    // 17-bit compare so poll_cnt_q + 1 cannot wrap against POLL_MAX
    always_comb begin
        more_poll_d = poll_q && rsp_busy_q &&
                      (({1'b0, poll_cnt_q} + 17'd1) < {1'b0, POLL_MAX});
    end

    assign on_bus = (state_q == S_SETUP) || (state_q == S_EN_HI) ||
                    (state_q == S_HOLD)  || (state_q == S_RECOVER);

    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            state_q       <= S_IDLE;
            phase_q       <= '0;
            poll_cnt_q    <= '0;
            rs_q          <= 1'b0;
            poll_q        <= 1'b0;
            bus_req_q     <= 1'b0;
            lcd_rs_q      <= 1'b0;
            lcd_rw_q      <= 1'b0;
            lcd_en_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_busy_q    <= 1'b0;
            rsp_addr_q    <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rd.req_valid) begin
                        rs_q          <= rd.req_rs;
                        poll_q        <= rd.req_poll & ~rd.req_rs;
                        poll_cnt_q    <= '0;
                        rsp_err_q     <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        bus_req_q     <= 1'b1;
                        state_q       <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (bus_gnt) begin
                        lcd_rw_q <= 1'b1;
                        lcd_rs_q <= rs_q;
                        phase_q  <= 8'(T_AS - 1);
                        state_q  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (phase_q == '0) begin
                        lcd_en_q <= 1'b1;
                        phase_q  <= 8'(T_EH - 1);
                        state_q  <= S_EN_HI;
                    end else begin
                        phase_q <= phase_q - 8'd1;
                    end
                end
                S_EN_HI: begin
                    if (phase_q == '0) begin
                        rsp_data_q <= LCD_DATA_IN;
                        if (!rs_q) begin
                            rsp_busy_q <= LCD_DATA_IN[7];
                            rsp_addr_q <= LCD_DATA_IN[6:0];
                        end
                        lcd_en_q <= 1'b0;
                        phase_q  <= 8'(T_HOLD - 1);
                        state_q  <= S_HOLD;
                    end else begin
                        phase_q <= phase_q - 8'd1;
                    end
                end
                // HOLD and RECOVER share the end-of-read decision so RECOVER can be skipped
                S_HOLD, S_RECOVER: begin
                    if (phase_q != '0) begin
                        phase_q <= phase_q - 8'd1;
                    end else if (state_q == S_HOLD && T_REC > 0) begin
                        phase_q <= 8'(T_REC - 1);
                        state_q <= S_RECOVER;
                    end else if (more_poll_d) begin
                        poll_cnt_q <= poll_cnt_q + 16'd1;
                        phase_q    <= 8'(T_AS - 1);
                        state_q    <= S_SETUP;
                    end else begin
                        rsp_timeout_q <= poll_q && rsp_busy_q;
                        rsp_valid_q   <= 1'b1;
                        bus_req_q     <= 1'b0;
                        lcd_rw_q      <= 1'b0;
                        lcd_rs_q      <= 1'b0;
                        state_q       <= S_DONE;
                    end
                end
                S_DONE: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Grant loss is only recorded; timing of the read is left untouched
            if (on_bus && !bus_gnt) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign rd.req_ready   = (state_q == S_IDLE) && KEY0;
    assign rd.rsp_valid   = rsp_valid_q;
    assign rd.rsp_data    = rsp_data_q;
    assign rd.rsp_busy    = rsp_busy_q;
    assign rd.rsp_addr    = rsp_addr_q;
    assign rd.rsp_timeout = rsp_timeout_q;
    assign rd.rsp_err     = rsp_err_q;
    assign bus_req        = bus_req_q;
    assign LCD_RS         = lcd_rs_q;
    assign LCD_RW         = lcd_rw_q;
    assign LCD_EN         = lcd_en_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Scoreboard bench for lcd_bus_reader: an LCD read model feeds bytes per EN pulse,
// expected responses are queued at request time and compared when rsp_valid fires.
module tb_lcd_bus_reader;

    localparam int TB_POLL_MAX = 4;
    localparam int T_EH        = 25;
    localparam int T_CYC       = 50;
    localparam int BASE_LAT    = 52;

    typedef struct {
        logic [7:0] data;
        logic       busy;
        logic [6:0] addr;
        logic       timeout;
        logic       err;
        int         cyc;
    } exp_t;

    logic       CLOCK_50 = 1'b0;
    logic       KEY0;
    logic       bus_req;
    logic       bus_gnt;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;
    logic [7:0] LCD_DATA_IN = 8'h00;

    lcd_bus_reader_if rif ();

    lcd_bus_reader #(.POLL_MAX(16'(TB_POLL_MAX))) dut (
        .CLOCK_50    (CLOCK_50),
        .KEY0        (KEY0),
        .rd          (rif),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .LCD_RS      (LCD_RS),
        .LCD_RW      (LCD_RW),
        .LCD_EN      (LCD_EN),
        .LCD_DATA_IN (LCD_DATA_IN)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_bad = 0;
    exp_t       sb[$];
    logic [7:0] lcd_vals[$];
    int         en_pulses = 0;
    int         exp_pulses = 0;
    int         last_rise = -1;
    int         en_run = 0;
    logic       en_prev = 1'b0;
    logic       cur_rs = 1'b0;
    logic       m_busy = 1'b0;
    logic [6:0] m_addr = '0;
    int         t0 = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // LCD model and response monitor
    always @(negedge CLOCK_50) begin
        if (KEY0 === 1'b1) begin
            if (LCD_EN && !en_prev) begin
                en_pulses++;
                if (last_rise >= 0) chk("en_spacing", cyc - last_rise, T_CYC);
                last_rise = cyc;
                chk("rs_at_en", LCD_RS, cur_rs);
                chk("rw_at_en", LCD_RW, 1'b1);
                if (lcd_vals.size() == 0)      LCD_DATA_IN = 8'h00;
                else if (lcd_vals.size() == 1) LCD_DATA_IN = lcd_vals[0];
                else                           LCD_DATA_IN = lcd_vals.pop_front();
            end
            if (!LCD_EN && en_prev) chk("en_width", en_run, T_EH);
            if (rif.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexp_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_cyc", cyc, e.cyc);
                    chk("rsp_data", rif.rsp_data, e.data);
                    chk("rsp_busy", rif.rsp_busy, e.busy);
                    chk("rsp_addr", rif.rsp_addr, e.addr);
                    chk("rsp_timeout", rif.rsp_timeout, e.timeout);
                    chk("rsp_err", rif.rsp_err, e.err);
                    chk("breq_at_done", bus_req, 1'b0);
                end
            end
        end
        en_run  = LCD_EN ? en_run + 1 : 0;
        en_prev = LCD_EN;
    end

    // Issues one request; returns at the negedge after acceptance (t0 = accept cycle)
    task automatic issue(input logic rs, input logic poll, input int extra, input logic err);
        exp_t       e;
        int         reads;
        int         bound;
        int         idx;
        logic [7:0] v;
        bound = 0;
        @(negedge CLOCK_50);
        while (!rif.req_ready && bound < 300) begin
            @(negedge CLOCK_50);
            bound++;
        end
        chk("req_ready_wait", rif.req_ready, 1'b1);
        reads = 0;
        do begin
            idx = (reads < lcd_vals.size()) ? reads : lcd_vals.size() - 1;
            v = (lcd_vals.size() == 0) ? 8'h00 : lcd_vals[idx];
            reads++;
        end while (!rs && poll && v[7] && reads < TB_POLL_MAX);
        if (!rs) begin
            m_busy = v[7];
            m_addr = v[6:0];
        end
        e.data    = v;
        e.busy    = m_busy;
        e.addr    = m_addr;
        e.timeout = !rs && poll && v[7];
        e.err     = err;
        e.cyc     = cyc + BASE_LAT + T_CYC * (reads - 1) + extra;
        sb.push_back(e);
        t0         = cyc;
        en_pulses  = 0;
        exp_pulses = reads;
        last_rise  = -1;
        cur_rs     = rs;
        rif.req_valid = 1'b1;
        rif.req_rs    = rs;
        rif.req_poll  = poll;
        @(negedge CLOCK_50);
        rif.req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("rsp_arrived", sb.size(), 0);
        sb.delete();
        chk("en_pulses", en_pulses, exp_pulses);
        repeat (3) @(negedge CLOCK_50);
    endtask

    initial begin
        int drops;
        KEY0          = 1'b0;
        bus_gnt       = 1'b1;
        rif.req_valid = 1'b0;
        rif.req_rs    = 1'b0;
        rif.req_poll  = 1'b0;

        // Reset state
        repeat (3) @(negedge CLOCK_50);
        chk("rst_en", LCD_EN, 1'b0);
        chk("rst_rw", LCD_RW, 1'b0);
        chk("rst_rs", LCD_RS, 1'b0);
        chk("rst_breq", bus_req, 1'b0);
        chk("rst_valid", rif.rsp_valid, 1'b0);
        chk("rst_data", rif.rsp_data, 8'h00);
        chk("rst_ready", rif.req_ready, 1'b0);
        KEY0 = 1'b1;
        #1 chk("ready_after_rst", rif.req_ready, 1'b1);

        // Status read with explicit RW/bus_req timing
        lcd_vals.delete();
        lcd_vals.push_back(8'h8A);
        issue(1'b0, 1'b0, 0, 1'b0);
        chk("arb_rw", LCD_RW, 1'b0);
        chk("arb_breq", bus_req, 1'b1);
        @(negedge CLOCK_50);
        chk("setup_rw", LCD_RW, 1'b1);
        chk("setup_en", LCD_EN, 1'b0);
        repeat (49) @(negedge CLOCK_50);
        chk("rec_rw", LCD_RW, 1'b1);
        chk("rec_breq", bus_req, 1'b1);
        @(negedge CLOCK_50);
        chk("done_rw", LCD_RW, 1'b0);
        chk("done_valid", rif.rsp_valid, 1'b1);
        wait_rsp();

        // Data read: busy/addr keep the previous status values
        lcd_vals.delete();
        lcd_vals.push_back(8'h41);
        issue(1'b1, 1'b0, 0, 1'b0);
        wait_rsp();

        // Poll success on the third read
        lcd_vals.delete();
        lcd_vals.push_back(8'h85);
        lcd_vals.push_back(8'h85);
        lcd_vals.push_back(8'h05);
        issue(1'b0, 1'b1, 0, 1'b0);
        drops = 0;
        for (int i = 0; i < 151; i++) begin
            if (!bus_req) drops++;
            @(negedge CLOCK_50);
        end
        chk("breq_cont", drops, 0);
        wait_rsp();

        // Poll timeout at POLL_MAX reads
        lcd_vals.delete();
        lcd_vals.push_back(8'h80);
        issue(1'b0, 1'b1, 0, 1'b0);
        wait_rsp();

        // Delayed grant, a one-cycle grant drop, stray requests mid-transaction
        lcd_vals.delete();
        lcd_vals.push_back(8'h33);
        bus_gnt = 1'b0;
        issue(1'b0, 1'b0, 9, 1'b1);
        repeat (9) @(negedge CLOCK_50);
        chk("arb_wait_rw", LCD_RW, 1'b0);
        bus_gnt = 1'b1;
        @(negedge CLOCK_50);
        chk("gnt_setup_rw", LCD_RW, 1'b1);
        repeat (4) @(negedge CLOCK_50);
        rif.req_valid = 1'b1;
        rif.req_rs    = 1'b1;
        @(negedge CLOCK_50);
        rif.req_valid = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        bus_gnt = 1'b0;
        @(negedge CLOCK_50);
        bus_gnt = 1'b1;
        wait_rsp();

        // Sticky error is cleared by the next accepted request
        lcd_vals.delete();
        lcd_vals.push_back(8'h27);
        issue(1'b0, 1'b0, 0, 1'b0);
        wait_rsp();

        // Reset during the fifth EN-high cycle
        lcd_vals.delete();
        lcd_vals.push_back(8'h8A);
        issue(1'b0, 1'b0, 0, 1'b0);
        repeat (7) @(negedge CLOCK_50);
        chk("pre_rst_en", LCD_EN, 1'b1);
        KEY0 = 1'b0;
        sb.delete();
        m_busy = 1'b0;
        m_addr = '0;
        @(negedge CLOCK_50);
        chk("abort_en", LCD_EN, 1'b0);
        chk("abort_rw", LCD_RW, 1'b0);
        chk("abort_breq", bus_req, 1'b0);
        chk("abort_ready", rif.req_ready, 1'b0);
        chk("abort_data", rif.rsp_data, 8'h00);
        @(negedge CLOCK_50);
        KEY0 = 1'b1;
        #1 chk("ready_after_abort", rif.req_ready, 1'b1);
        repeat (60) @(negedge CLOCK_50);
        chk("no_rsp_after_abort", rif.rsp_valid, 1'b0);

        // Fresh read after the abort
        lcd_vals.delete();
        lcd_vals.push_back(8'h12);
        issue(1'b0, 1'b0, 0, 1'b0);
        wait_rsp();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
